uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises framed 32-bit payloads from two requesters into a byte transmitter.
// Build option: define UART_TX_ARB_CHKSUM_EN to append a modulo-256 checksum byte to every frame.
module uart_tx_arbiter #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2499999
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [31:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        ack_b,
  input  logic        uart_tx_done,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_en,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;

`ifdef UART_TX_ARB_CHKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        gnt_b_q, gnt_b_d;
  logic        last_b_q, last_b_d;
  logic [7:0]  data_q, data_d;
  logic        en_q, en_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  chan_id;
  logic [7:0]  cur_byte;
  logic        pick_b;

  assign chan_id = gnt_b_q ? 8'h02 : 8'h01;
  // B wins when it is alone, or when both ask and A was served last.
  assign pick_b  = req_b && (!req_a || !last_b_q);

`ifdef UART_TX_ARB_CHKSUM_EN
  logic [7:0] chksum;
  assign chksum = chan_id + buf_q[7:0] + buf_q[15:8] + buf_q[23:16] + buf_q[31:24];
`endif

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      3'd0: cur_byte = HEADER;
      3'd1: cur_byte = chan_id;
      3'd2: cur_byte = buf_q[7:0];
      3'd3: cur_byte = buf_q[15:8];
      3'd4: cur_byte = buf_q[23:16];
      3'd5: cur_byte = buf_q[31:24];
`ifdef UART_TX_ARB_CHKSUM_EN
      3'd6: cur_byte = chksum;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    gnt_b_d  = gnt_b_q;
    last_b_d = last_b_q;
    data_d   = data_q;
    en_d     = 1'b0;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          gnt_b_d = pick_b;
          buf_d   = pick_b ? data_b : data_a;
          idx_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        data_d  = cur_byte;
        en_d    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        cnt_d   = 24'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Next byte goes through LOAD so every enable lands two cycles after done.
        if (uart_tx_done) begin
          if (idx_q == LAST_IDX) begin
            ack_a_d = !gnt_b_q;
            ack_b_d = gnt_b_q;
            state_d = S_ACK;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_LOAD;
          end
        end else if (cnt_q == TIMEOUT_CYC) begin
          err_d   = 1'b1;
          ack_a_d = !gnt_b_q;
          ack_b_d = gnt_b_q;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_ACK: begin
        last_b_d = gnt_b_q;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= 24'd0;
      buf_q    <= 32'd0;
      gnt_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      data_q   <= 8'h00;
      en_q     <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      gnt_b_q  <= gnt_b_d;
      last_b_q <= last_b_d;
      data_q   <= data_d;
      en_q     <= en_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign uart_tx_data = data_q;
  assign uart_tx_en   = en_q;
  assign ack_a        = ack_a_q;
  assign ack_b        = ack_b_q;
  assign busy         = busy_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: frame vector table plus arbitration, reset and timeout sequences.
module tb_uart_tx_arbiter;
`ifdef UART_TX_ARB_CHKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam logic [23:0] TO = 24'd20;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, ack_a, ack_b;
  logic [31:0] data_a, data_b;
  logic        uart_tx_done, uart_tx_en, busy, timeout_err;
  logic [7:0]  uart_tx_data;

  uart_tx_arbiter #(.HEADER(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .uart_tx_done(uart_tx_done), .uart_tx_data(uart_tx_data),
    .uart_tx_en(uart_tx_en), .busy(busy), .timeout_err(timeout_err)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    logic            use_b;
    logic [31:0]     payload;
    int              dly;
    logic [0:6][7:0] exp;
  } vec_t;

  vec_t       vecs [4];
  int         n_chk = 0, n_fail = 0, cyc = 0;
  int         rsp_cnt = 0, rsp_dly = 10;
  logic       rsp_on = 1'b1;
  logic [7:0] bytes_q [$];
  int         en_cyc [$];
  int         ack_log [$];
  int         ack_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: transmitter model answers enables with done after rsp_dly cycles; requesters drop on ack.
  task automatic tick();
    @(negedge clk_50m);
    cyc++;
    uart_tx_done = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) uart_tx_done = 1'b1;
    end
    if (uart_tx_en) begin
      bytes_q.push_back(uart_tx_data);
      en_cyc.push_back(cyc);
      if (rsp_on) rsp_cnt = rsp_dly;
    end
    if (ack_a) begin ack_log.push_back(1); ack_cyc.push_back(cyc); end
    if (ack_b) begin ack_log.push_back(2); ack_cyc.push_back(cyc); end
  endtask

  task automatic clear_logs();
    bytes_q.delete(); en_cyc.delete(); ack_log.delete(); ack_cyc.delete();
  endtask

  task automatic do_reset();
    req_a = 1'b0; req_b = 1'b0; rsp_cnt = 0; uart_tx_done = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
  endtask

  // Drops each requester when its ack is seen, except A when hold_a is set.
  task automatic wait_acks(input int n, input int budget, input logic hold_a);
    int k = 0;
    while (ack_log.size() < n && k < budget) begin
      tick();
      if (ack_a && !hold_a) req_a = 1'b0;
      if (ack_b) req_b = 1'b0;
      k++;
    end
    chk("ack_count_reached", ack_log.size(), n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, uart_tx_data, 8'h00);
    chk({tag, "_en"}, uart_tx_en, 1'b0);
    chk({tag, "_ack_a"}, ack_a, 1'b0);
    chk({tag, "_ack_b"}, ack_b, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    int t0;
    int k;
    vecs[0] = '{1'b0, 32'h12345678, 10, {8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15}};
    vecs[1] = '{1'b1, 32'hDEADBEEF, 3,  {8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h3A}};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 1,  {8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD}};
    vecs[3] = '{1'b1, 32'h00000000, 5,  {8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02}};

    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0; uart_tx_done = 1'b0;
    tick(); tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Spurious done while idle
    uart_tx_done = 1'b1;
    repeat (5) tick();
    chk("idle_done_no_en", en_cyc.size(), 0);
    chk("idle_done_busy", busy, 1'b0);

    for (int v = 0; v < 4; v++) begin
      clear_logs();
      rsp_on = 1'b1; rsp_dly = vecs[v].dly;
      t0 = cyc;
      if (vecs[v].use_b) begin data_b = vecs[v].payload; req_b = 1'b1; end
      else begin data_a = vecs[v].payload; req_a = 1'b1; end
      tick();
      chk("busy_in_load", busy, 1'b1);
      data_a = ~vecs[v].payload; data_b = ~vecs[v].payload;
      wait_acks(1, 400, 1'b0);
      if (ack_log.size() > 0) begin
        chk("ack_channel", ack_log[0], vecs[v].use_b ? 2 : 1);
        if (en_cyc.size() == NB)
          chk("ack_latency", ack_cyc[0] - en_cyc[NB-1], vecs[v].dly + 1);
      end
      tick();
      chk("busy_after_ack", busy, 1'b0);
      chk("single_ack", ack_log.size(), 1);
      chk("frame_len", bytes_q.size(), NB);
      for (int i = 0; i < NB; i++) begin
        if (i < bytes_q.size()) chk("frame_byte", bytes_q[i], vecs[v].exp[i]);
        if (i == 0 && en_cyc.size() > 0) chk("first_en_latency", en_cyc[0] - t0, 2);
        if (i > 0 && i < en_cyc.size()) chk("en_gap", en_cyc[i] - en_cyc[i-1], vecs[v].dly + 2);
      end
    end

    // Simultaneous requests after reset: A then B
    do_reset();
    rsp_dly = 2; data_a = 32'h11223344; data_b = 32'h55667788;
    req_a = 1'b1; req_b = 1'b1;
    wait_acks(2, 600, 1'b0);
    if (ack_log.size() == 2) begin
      chk("both_first_ack", ack_log[0], 1);
      chk("both_second_ack", ack_log[1], 2);
    end
    if (bytes_q.size() >= 2 * NB) begin
      chk("both_a_id", bytes_q[1], 8'h01);
      chk("both_b_hdr", bytes_q[NB], 8'hA5);
      chk("both_b_id", bytes_q[NB+1], 8'h02);
    end else chk("both_len", bytes_q.size(), 2 * NB);

    // A held continuously, B arrives mid-frame: B served next
    do_reset();
    req_a = 1'b1;
    repeat (6) tick();
    req_b = 1'b1;
    wait_acks(2, 600, 1'b1);
    if (ack_log.size() == 2) begin
      chk("rr_first", ack_log[0], 1);
      chk("rr_second", ack_log[1], 2);
    end
    if (bytes_q.size() >= NB + 2) chk("rr_b_id", bytes_q[NB+1], 8'h02);

    // Reset after the third byte aborts the frame
    do_reset();
    rsp_dly = 4; data_a = 32'hCAFEF00D;
    req_a = 1'b1;
    k = 0;
    while (bytes_q.size() < 3 && k < 200) begin tick(); k++; end
    chk("abort_third_byte", bytes_q.size(), 3);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    rsp_cnt = 0;
    repeat (3) tick();
    chk("abort_no_ack", ack_log.size(), 0);
    clear_logs();
    rst_n = 1'b1;
    wait_acks(1, 400, 1'b0);
    chk("restart_len", bytes_q.size(), NB);
    if (bytes_q.size() >= 2) begin
      chk("restart_hdr", bytes_q[0], 8'hA5);
      chk("restart_id", bytes_q[1], 8'h01);
    end

    // No done after the first enable: timeout
    do_reset();
    rsp_on = 1'b0;
    req_a = 1'b1;
    tick();
    chk("to_err_before", timeout_err, 1'b0);
    wait_acks(1, 200, 1'b0);
    chk("to_err_at_ack", timeout_err, 1'b1);
    chk("to_bytes", bytes_q.size(), 1);
    if (ack_cyc.size() > 0 && en_cyc.size() > 0)
      chk("to_latency", ack_cyc[0] - en_cyc[0], 32'(TO) + 2);
    tick();
    chk("to_busy_low", busy, 1'b0);
    rsp_on = 1'b1; rsp_dly = 2;
    req_b = 1'b1;
    wait_acks(2, 400, 1'b0);
    if (ack_log.size() == 2) chk("to_next_chan", ack_log[1], 2);
    chk("to_err_sticky", timeout_err, 1'b1);
    do_reset();
    chk("to_err_cleared", timeout_err, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
